// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with prioritised redirects, pending latch and return-address stack
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   pc_en              1 = PC may advance, 0 = stall (pc_out holds)
//   exc_req            exception redirect to EXC_VECTOR (rank 4)
//   br_taken/br_target resolved branch redirect (rank 3)
//   ras_pop            pop return stack and redirect to popped value (rank 2)
//   jump/jump_target   jump redirect (rank 1)
//   ras_push/_addr     push return address onto the return stack
//   pc_out             registered fetch PC
//   pc_plus_inc        pc_out + INC, wrapping
//   redirect_pending   a redirect captured during a stall awaits pc_en
//   ras_empty/full     return stack occupancy flags
//   ras_top            top-of-stack value, 0 when empty

module pc_unit #(
    parameter int                 WIDTH        = 32,
    parameter int                 INC          = 4,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = 32'h8000_0180,
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_en,
    input  logic             exc_req,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             ras_push,
    input  logic [WIDTH-1:0] ras_push_addr,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic             redirect_pending,
    output logic             ras_empty,
    output logic             ras_full,
    output logic [WIDTH-1:0] ras_top
);

    localparam int              PTR_W        = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]  RAS_FULL_CNT = (PTR_W+1)'(RAS_DEPTH);

    // Rank encoding: 0 means "no redirect", larger wins.
    localparam logic [2:0] RANK_NONE = 3'd0;
    localparam logic [2:0] RANK_JUMP = 3'd1;
    localparam logic [2:0] RANK_POP  = 3'd2;
    localparam logic [2:0] RANK_BR   = 3'd3;
    localparam logic [2:0] RANK_EXC  = 3'd4;

    logic [WIDTH-1:0] pc_q;
    logic [2:0]       pend_rank;
    logic [WIDTH-1:0] pend_target;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;     // next write slot; top lives at ras_ptr-1
    logic [PTR_W:0]   ras_cnt;

    logic [PTR_W-1:0] top_idx;
    logic [WIDTH-1:0] top_val;
    logic             pop_valid;

    logic [2:0]       cand_rank;
    logic [WIDTH-1:0] cand_target;

    assign top_idx   = ras_ptr - 1'b1;
    assign top_val   = ras_mem[top_idx];
    assign pop_valid = ras_pop && (ras_cnt != '0);

    // Highest-ranked request of this cycle; later assignments override earlier ones.
    always_comb begin
        cand_rank   = RANK_NONE;
        cand_target = '0;
        if (jump) begin
            cand_rank   = RANK_JUMP;
            cand_target = jump_target;
        end
        if (pop_valid) begin
            cand_rank   = RANK_POP;
            cand_target = top_val;
        end
        if (br_taken) begin
            cand_rank   = RANK_BR;
            cand_target = br_target;
        end
        if (exc_req) begin
            cand_rank   = RANK_EXC;
            cand_target = EXC_VECTOR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            pend_rank   <= RANK_NONE;
            pend_target <= '0;
            ras_ptr     <= '0;
            ras_cnt     <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            if (pc_en) begin
                // Ties go to the current request, so it is compared with >=.
                if (cand_rank != RANK_NONE && cand_rank >= pend_rank) begin
                    pc_q <= cand_target;
                end else if (pend_rank != RANK_NONE) begin
                    pc_q <= pend_target;
                end else begin
                    pc_q <= pc_q + WIDTH'(INC);
                end
                pend_rank   <= RANK_NONE;
                pend_target <= '0;
            end else if (cand_rank != RANK_NONE && cand_rank >= pend_rank) begin
                pend_rank   <= cand_rank;
                pend_target <= cand_target;
            end

            // Return stack runs independently of stalls and of the redirect outcome.
            if (ras_push && pop_valid) begin
                // Pop returns the old top; the pushed address takes its slot.
                ras_mem[top_idx] <= ras_push_addr;
            end else if (ras_push) begin
                ras_mem[ras_ptr] <= ras_push_addr;
                ras_ptr          <= ras_ptr + 1'b1;
                if (ras_cnt != RAS_FULL_CNT) begin
                    ras_cnt <= ras_cnt + 1'b1;
                end
            end else if (pop_valid) begin
                ras_ptr <= ras_ptr - 1'b1;
                ras_cnt <= ras_cnt - 1'b1;
            end
        end
    end

    assign pc_out           = pc_q;
    assign pc_plus_inc      = pc_q + WIDTH'(INC);
    assign redirect_pending = (pend_rank != RANK_NONE);
    assign ras_empty        = (ras_cnt == '0);
    assign ras_full         = (ras_cnt == RAS_FULL_CNT);
    assign ras_top          = (ras_cnt == '0) ? '0 : top_val;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard testbench for pc_unit
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, pc_en, exc_req, br_taken, jump, ras_push, ras_pop;
    logic [31:0] br_target, jump_target, ras_push_addr;
    logic [31:0] pc_out, pc_plus_inc, ras_top;
    logic        redirect_pending, ras_empty, ras_full;

    always #5 clk = ~clk;

    pc_unit #(
        .WIDTH(32), .INC(4), .RESET_VECTOR(32'h0000_0000),
        .EXC_VECTOR(32'h8000_0180), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .pc_en(pc_en), .exc_req(exc_req),
        .br_taken(br_taken), .br_target(br_target),
        .jump(jump), .jump_target(jump_target),
        .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
        .pc_out(pc_out), .pc_plus_inc(pc_plus_inc),
        .redirect_pending(redirect_pending),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_top(ras_top)
    );

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [31:0] pc_inc;
        logic        pend;
        logic        empty;
        logic        full;
        logic [31:0] top;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   step_id = 0;

    task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, id, act, want);
        end
    endtask

    // Monitor: after every rising edge compare the DUT state with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("pc_out",           e.id, pc_out,                   e.pc);
                cmp("pc_plus_inc",      e.id, pc_plus_inc,              e.pc_inc);
                cmp("redirect_pending", e.id, {31'b0, redirect_pending}, {31'b0, e.pend});
                cmp("ras_empty",        e.id, {31'b0, ras_empty},        {31'b0, e.empty});
                cmp("ras_full",         e.id, {31'b0, ras_full},         {31'b0, e.full});
                cmp("ras_top",          e.id, ras_top,                   e.top);
            end
        end
    end

    // One cycle of stimulus; expectations describe the state after the next rising edge.
    task automatic step(
        input logic rst, input logic en, input logic exc,
        input logic br, input logic [31:0] bt,
        input logic jmp, input logic [31:0] jt,
        input logic psh, input logic [31:0] pa, input logic pop,
        input logic [31:0] e_pc, input logic [31:0] e_inc, input logic e_pend,
        input logic e_empty, input logic e_full, input logic [31:0] e_top
    );
        exp_t e;
        reset = rst; pc_en = en; exc_req = exc;
        br_taken = br; br_target = bt;
        jump = jmp; jump_target = jt;
        ras_push = psh; ras_push_addr = pa; ras_pop = pop;
        step_id++;
        e.id = step_id; e.pc = e_pc; e.pc_inc = e_inc; e.pend = e_pend;
        e.empty = e_empty; e.full = e_full; e.top = e_top;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; pc_en = 1'b0; exc_req = 1'b0; br_taken = 1'b0; jump = 1'b0;
        ras_push = 1'b0; ras_pop = 1'b0;
        br_target = '0; jump_target = '0; ras_push_addr = '0;

        //    rst en exc br bt            jmp jt            psh pa          pop  pc            pc+4          pnd emp ful top
        // Reset state, then sequential fetch
        step(1, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   0, 32'h0000_0000, 32'h0000_0004, 0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   0, 32'h0000_0004, 32'h0000_0008, 0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   0, 32'h0000_0008, 32'h0000_000C, 0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   0, 32'h0000_000C, 32'h0000_0010, 0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   0, 32'h0000_0010, 32'h0000_0014, 0, 1, 0, 32'h0);
        // Branch beats jump in the same cycle
        step(0, 1, 0, 1, 32'h100,     1, 32'h200,     0, 32'h0,   0, 32'h0000_0100, 32'h0000_0104, 0, 1, 0, 32'h0);
        // Stall: jump latched, then branch upgrades it, released on pc_en
        step(0, 0, 0, 0, 32'h0,       1, 32'h200,     0, 32'h0,   0, 32'h0000_0100, 32'h0000_0104, 1, 1, 0, 32'h0);
        step(0, 0, 0, 1, 32'h300,     0, 32'h0,       0, 32'h0,   0, 32'h0000_0100, 32'h0000_0104, 1, 1, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   0, 32'h0000_0100, 32'h0000_0104, 1, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   0, 32'h0000_0300, 32'h0000_0304, 0, 1, 0, 32'h0);
        // Pending branch overridden by exception on release
        step(0, 0, 0, 1, 32'h300,     0, 32'h0,       0, 32'h0,   0, 32'h0000_0300, 32'h0000_0304, 1, 1, 0, 32'h0);
        step(0, 1, 1, 0, 32'h0,       0, 32'h0,       0, 32'h0,   0, 32'h8000_0180, 32'h8000_0184, 0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   0, 32'h8000_0184, 32'h8000_0188, 0, 1, 0, 32'h0);
        // Lower-ranked jump during stall is dropped
        step(0, 0, 0, 1, 32'h400,     0, 32'h0,       0, 32'h0,   0, 32'h8000_0184, 32'h8000_0188, 1, 1, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0,       1, 32'h500,     0, 32'h0,   0, 32'h8000_0184, 32'h8000_0188, 1, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   0, 32'h0000_0400, 32'h0000_0404, 0, 1, 0, 32'h0);
        // Equal rank: current request beats pending one
        step(0, 0, 0, 1, 32'h600,     0, 32'h0,       0, 32'h0,   0, 32'h0000_0400, 32'h0000_0404, 1, 1, 0, 32'h0);
        step(0, 1, 0, 1, 32'h700,     0, 32'h0,       0, 32'h0,   0, 32'h0000_0700, 32'h0000_0704, 0, 1, 0, 32'h0);
        // RAS fill and overflow
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       1, 32'hA0,  0, 32'h0000_0704, 32'h0000_0708, 0, 0, 0, 32'hA0);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       1, 32'hA4,  0, 32'h0000_0708, 32'h0000_070C, 0, 0, 0, 32'hA4);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       1, 32'hA8,  0, 32'h0000_070C, 32'h0000_0710, 0, 0, 0, 32'hA8);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       1, 32'hAC,  0, 32'h0000_0710, 32'h0000_0714, 0, 0, 1, 32'hAC);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       1, 32'hB0,  0, 32'h0000_0714, 32'h0000_0718, 0, 0, 1, 32'hB0);
        // Five pops: four redirects, the fifth ignored
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   1, 32'h0000_00B0, 32'h0000_00B4, 0, 0, 0, 32'hAC);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   1, 32'h0000_00AC, 32'h0000_00B0, 0, 0, 0, 32'hA8);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   1, 32'h0000_00A8, 32'h0000_00AC, 0, 0, 0, 32'hA4);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   1, 32'h0000_00A4, 32'h0000_00A8, 0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   1, 32'h0000_00A8, 32'h0000_00AC, 0, 1, 0, 32'h0);
        // Simultaneous push/pop, non-empty then empty
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       1, 32'hC0,  0, 32'h0000_00AC, 32'h0000_00B0, 0, 0, 0, 32'hC0);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       1, 32'hD0,  1, 32'h0000_00C0, 32'h0000_00C4, 0, 0, 0, 32'hD0);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   1, 32'h0000_00D0, 32'h0000_00D4, 0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       1, 32'hE0,  1, 32'h0000_00D4, 32'h0000_00D8, 0, 0, 0, 32'hE0);
        // Pop loses to exception but still updates the stack
        step(0, 1, 1, 0, 32'h0,       0, 32'h0,       0, 32'h0,   1, 32'h8000_0180, 32'h8000_0184, 0, 1, 0, 32'h0);
        // Wrap-around at top of address space
        step(0, 1, 0, 0, 32'h0,       1, 32'hFFFF_FFF8, 0, 32'h0, 0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   0, 32'hFFFF_FFFC, 32'h0000_0000, 0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   0, 32'h0000_0000, 32'h0000_0004, 0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   0, 32'h0000_0004, 32'h0000_0008, 0, 1, 0, 32'h0);
        // Reset while a redirect is pending and the stack holds data
        step(0, 0, 0, 0, 32'h0,       1, 32'h900,     1, 32'hF0,  0, 32'h0000_0004, 32'h0000_0008, 1, 0, 0, 32'hF0);
        step(1, 1, 0, 1, 32'h950,     0, 32'h0,       0, 32'h0,   0, 32'h0000_0000, 32'h0000_0004, 0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,   0, 32'h0000_0004, 32'h0000_0008, 0, 1, 0, 32'h0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
